// File: rtl/systolic_feed_sequencer.sv
// rtl/systolic_feed_sequencer.sv - job sequencer and diagonal skew feed for the systolic array
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start, k_len        job request and beat count, sampled only in IDLE
//   simd_mode           SIMD mode, latched onto SIMD_control at an accepted start
//   in_valid, in_ready  beat handshake; in_ready is high only in LOAD
//   a_vec, b_vec        one A column / B row per beat, lane i at [i*WIDTH +: WIDTH]
//   out_a, out_b        skewed west/north feeds, lane i delayed 1+i cycles
//   done_flag           one-cycle pulse when the last beat's lane 0 is presented
//   busy                high in LOAD and DRAIN

// One lane of the skew: a DEPTH-stage shift register whose input is the
// accepted lane value, or zero in a slot with no accept.
module systolic_feed_skew_lane #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH*WIDTH-1:0] sr;
    logic [WIDTH-1:0]       slot;

    assign slot = load ? din : '0;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else begin
                    sr <= slot;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[(DEPTH-1)*WIDTH-1:0], slot};
                end
            end
        end
    endgenerate

    assign dout = sr[(DEPTH-1)*WIDTH +: WIDTH];
endmodule

module systolic_feed_sequencer #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int K_BITS     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [K_BITS-1:0]           k_len,
    input  logic [1:0]                  simd_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0] a_vec,
    input  logic [ARR_WIDTH*WIDTH-1:0]  b_vec,
    output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
    output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
    output logic [1:0]                  SIMD_control,
    output logic                        done_flag,
    output logic                        busy
);
    // Deepest lane delay beyond the first stage; DRAIN lasts this many cycles.
    localparam int D          = ((ARR_HEIGHT > ARR_WIDTH) ? ARR_HEIGHT : ARR_WIDTH) - 1;
    localparam int DRAIN_BITS = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [K_BITS-1:0]     remaining;
    logic [DRAIN_BITS-1:0] drain_cnt;
    logic                  accept;
    logic                  last_accept;
    logic                  job_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        job_start   = 1'b0;
        case (state)
            S_IDLE: begin
                // A zero-length job is illegal and simply ignored.
                if (start && (k_len != '0)) begin
                    job_start  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && (remaining == K_BITS'(1))) begin
                    last_accept = 1'b1;
                    state_next  = (D == 0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining    <= '0;
            drain_cnt    <= '0;
            SIMD_control <= 2'b00;
            done_flag    <= 1'b0;
        end else begin
            // The last beat's lane 0 leaves its single stage on the next cycle.
            done_flag <= last_accept;
            if (job_start) begin
                remaining    <= k_len;
                SIMD_control <= simd_mode;
            end else if (accept) begin
                remaining <= remaining - K_BITS'(1);
            end
            // drain_cnt holds the DRAIN cycles left after the current one.
            if (last_accept) begin
                drain_cnt <= DRAIN_BITS'(D - 1);
            end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_BITS'(1);
            end
        end
    end

    // Idle slots feed zeros on every lane at once, so A and B stay slot-aligned.
    genvar gi;
    generate
        for (gi = 0; gi < ARR_HEIGHT; gi++) begin : g_a_lane
            systolic_feed_skew_lane #(
                .WIDTH (WIDTH),
                .DEPTH (gi + 1)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .load  (accept),
                .din   (a_vec[gi*WIDTH +: WIDTH]),
                .dout  (out_a[gi*WIDTH +: WIDTH])
            );
        end
        for (gi = 0; gi < ARR_WIDTH; gi++) begin : g_b_lane
            systolic_feed_skew_lane #(
                .WIDTH (WIDTH),
                .DEPTH (gi + 1)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .load  (accept),
                .din   (b_vec[gi*WIDTH +: WIDTH]),
                .dout  (out_b[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate
endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// tb/tb_systolic_feed_sequencer.sv - self-checking bench for systolic_feed_sequencer
module tb_systolic_feed_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  k_len = 8'd0;
    logic [1:0]  simd_mode = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a_vec = '0;
    logic [63:0] b_vec = '0;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [1:0]  simd_ctl;
    logic        done_flag;
    logic        busy;

    logic        ns_start = 1'b0;
    logic [7:0]  ns_k_len = 8'd0;
    logic [1:0]  ns_simd = 2'b00;
    logic        ns_in_valid = 1'b0;
    logic        ns_in_ready;
    logic [31:0] ns_a = '0;
    logic [63:0] ns_b = '0;
    logic [31:0] ns_out_a;
    logic [63:0] ns_out_b;
    logic [1:0]  ns_simd_ctl;
    logic        ns_done;
    logic        ns_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;

    // Bench model of the 4x4 instance.
    int m_state = 0;
    int m_cnt = 0;
    int m_drain = 0;
    logic [1:0]  m_simd = 2'b00;
    logic        m_done = 1'b0;
    logic [63:0] hist_a[$];
    logic [63:0] hist_b[$];

    always #5 clk = ~clk;

    systolic_feed_sequencer #(
        .WIDTH(16), .ARR_HEIGHT(4), .ARR_WIDTH(4), .K_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .simd_mode(simd_mode), .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .b_vec(b_vec), .out_a(out_a), .out_b(out_b),
        .SIMD_control(simd_ctl), .done_flag(done_flag), .busy(busy)
    );

    systolic_feed_sequencer #(
        .WIDTH(16), .ARR_HEIGHT(2), .ARR_WIDTH(4), .K_BITS(8)
    ) dut_ns (
        .clk(clk), .reset(reset), .start(ns_start), .k_len(ns_k_len),
        .simd_mode(ns_simd), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
        .a_vec(ns_a), .b_vec(ns_b), .out_a(ns_out_a), .out_b(ns_out_b),
        .SIMD_control(ns_simd_ctl), .done_flag(ns_done), .busy(ns_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] lanes4(input logic [15:0] base, input logic [15:0] step);
        logic [15:0] l1, l2, l3;
        l1 = base + step;
        l2 = l1 + step;
        l3 = l2 + step;
        return {l3, l2, l1, base};
    endfunction

    function automatic logic [15:0] lane(input logic [63:0] v, input int i);
        return v[i*16 +: 16];
    endfunction

    // Advance one clock: update the model from the inputs about to be
    // sampled, then compare every 4x4 output #1 after the edge.
    task automatic tick();
        logic        acc;
        logic [63:0] ea, eb, ha, hb;
        acc = (m_state == 1) && in_valid;
        if (reset) begin
            m_state = 0;
            m_cnt   = 0;
            m_drain = 0;
            m_simd  = 2'b00;
            m_done  = 1'b0;
            hist_a  = {};
            hist_b  = {};
            for (int i = 0; i < 4; i++) begin
                hist_a.push_back('0);
                hist_b.push_back('0);
            end
        end else begin
            m_done = acc && (m_cnt == 1);
            hist_a.push_back(acc ? a_vec : 64'd0);
            hist_b.push_back(acc ? b_vec : 64'd0);
            void'(hist_a.pop_front());
            void'(hist_b.pop_front());
            case (m_state)
                0: if (start && (k_len != 8'd0)) begin
                    m_state = 1;
                    m_cnt   = int'(k_len);
                    m_simd  = simd_mode;
                end
                1: if (acc) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_state = 2;
                        m_drain = 3;
                    end
                end
                default: begin
                    m_drain = m_drain - 1;
                    if (m_drain == 0) m_state = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done_flag === 1'b1) n_done++;
        ea = '0;
        eb = '0;
        for (int i = 0; i < 4; i++) begin
            ha = hist_a[3-i];
            hb = hist_b[3-i];
            ea[i*16 +: 16] = ha[i*16 +: 16];
            eb[i*16 +: 16] = hb[i*16 +: 16];
        end
        chk("out_a", out_a, ea);
        chk("out_b", out_b, eb);
        chk("done_flag", done_flag, m_done);
        chk("busy", busy, m_state != 0);
        chk("in_ready", in_ready, m_state == 1);
        chk("SIMD_control", simd_ctl, m_simd);
    endtask

    initial begin
        logic [15:0] v16;
        logic [63:0] x, y, exp64;
        int p;
        int d0;

        // Reset state of both instances.
        reset = 1'b1;
        tick();
        tick();
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("ns_rst_out_b", ns_out_b, 64'd0);
        chk("ns_rst_busy", ns_busy, 1'b0);
        reset = 1'b0;

        // Basic job: k_len=3, beats accepted at rel 1,2,3.
        for (int r = 0; r <= 8; r++) begin
            start     = (r == 0);
            k_len     = 8'd3;
            simd_mode = 2'b00;
            in_valid  = 1'b1;
            v16       = 16'h0010 + 16'(r);
            a_vec     = {v16, v16, v16, v16};
            b_vec     = lanes4(16'h0100 + 16'(r), 16'h1000);
            tick();
            p = r + 1;
            chk("basic_lane2", lane(out_a, 2), (p >= 4 && p <= 6) ? 16'h0010 + 16'(p - 3) : 16'd0);
            chk("basic_done", done_flag, p == 4);
            chk("basic_busy", busy, p < 7);
        end
        start = 1'b0;

        // Bubbles: valid 1,0,1 with garbage on the idle slot.
        x = lanes4(16'hA000, 16'h0101);
        y = lanes4(16'hB000, 16'h0101);
        for (int r = 0; r <= 8; r++) begin
            start    = (r == 0);
            k_len    = 8'd2;
            in_valid = (r == 1) || (r == 3);
            a_vec    = (r == 1) ? x : (r == 3) ? y : lanes4(16'hDEAD, 16'h0001);
            b_vec    = (r == 1) ? ~x : (r == 3) ? ~y : lanes4(16'hBEEF, 16'h0001);
            tick();
            p = r + 1;
            chk("bubble_lane0", lane(out_a, 0), (p == 2) ? 16'hA000 : (p == 4) ? 16'hB000 : 16'd0);
            chk("bubble_lane3", lane(out_a, 3), (p == 5) ? 16'hA303 : (p == 7) ? 16'hB303 : 16'd0);
            chk("bubble_done", done_flag, p == 4);
            chk("bubble_busy", busy, p < 7);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Ignored starts: k_len=0 in IDLE, then repeated starts while busy.
        start     = 1'b1;
        k_len     = 8'd0;
        simd_mode = 2'b11;
        tick();
        chk("klen0_busy", busy, 1'b0);
        chk("klen0_simd", simd_ctl, 2'b00);
        for (int r = 0; r <= 7; r++) begin
            start     = (r <= 4);
            k_len     = (r == 0) ? 8'd2 : 8'd7;
            simd_mode = (r == 0) ? 2'b01 : 2'b11;
            in_valid  = (r >= 1);
            a_vec     = lanes4(16'h3000 + 16'(r), 16'h0010);
            b_vec     = lanes4(16'h4000 + 16'(r), 16'h0010);
            tick();
            p = r + 1;
            chk("busystart_done", done_flag, p == 3);
            chk("busystart_busy", busy, p < 6);
            chk("busystart_simd", simd_ctl, 2'b01);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // SIMD latch: mode changes mid-job must not propagate.
        for (int r = 0; r <= 9; r++) begin
            start     = (r == 0);
            k_len     = 8'd3;
            simd_mode = (r < 2) ? 2'b10 : 2'b01;
            in_valid  = 1'b1;
            a_vec     = {$urandom, $urandom};
            b_vec     = {$urandom, $urandom};
            tick();
            p = r + 1;
            chk("simd_hold", simd_ctl, 2'b10);
            chk("simd_busy", busy, p < 7);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Reset after 2 of 5 beats.
        for (int r = 0; r <= 3; r++) begin
            start     = (r == 0);
            k_len     = 8'd5;
            simd_mode = 2'b11;
            in_valid  = (r >= 1);
            reset     = (r == 3);
            a_vec     = lanes4(16'h6000 + 16'(r), 16'h0011);
            b_vec     = lanes4(16'h7000 + 16'(r), 16'h0011);
            tick();
        end
        chk("rstmid_out_a", out_a, 64'd0);
        chk("rstmid_out_b", out_b, 64'd0);
        chk("rstmid_done", done_flag, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_in_ready", in_ready, 1'b0);
        chk("rstmid_simd", simd_ctl, 2'b00);
        reset    = 1'b0;
        start    = 1'b0;
        for (int r = 0; r < 6; r++) begin
            tick();
            chk("rstmid_idle_done", done_flag, 1'b0);
            chk("rstmid_idle_busy", busy, 1'b0);
        end
        in_valid = 1'b0;
        for (int r = 0; r <= 6; r++) begin
            start    = (r == 0);
            k_len    = 8'd1;
            in_valid = (r == 1);
            a_vec    = lanes4(16'h5000, 16'h0111);
            b_vec    = lanes4(16'h5800, 16'h0111);
            tick();
            p = r + 1;
            chk("k1_done", done_flag, p == 2);
            chk("k1_busy", busy, p < 5);
            chk("k1_b_lane3", lane(out_b, 3), (p == 5) ? 16'h5B33 : 16'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Longest job: 255 beats without counter wrap.
        d0 = n_done;
        for (int r = 0; r <= 262; r++) begin
            start    = (r == 0);
            k_len    = 8'd255;
            in_valid = 1'b1;
            a_vec    = {$urandom, $urandom};
            b_vec    = {$urandom, $urandom};
            tick();
            p = r + 1;
            chk("k255_busy", busy, p < 259);
            chk("k255_done", done_flag, p == 256);
        end
        chk("k255_done_count", 64'(n_done - d0), 64'd1);
        start    = 1'b0;
        in_valid = 1'b0;

        // Non-square 2x4 instance, k_len=1 accepted at rel 1.
        for (int r = 0; r <= 7; r++) begin
            ns_start    = (r == 0);
            ns_k_len    = 8'd1;
            ns_in_valid = (r == 1);
            ns_a        = (r == 1) ? {16'hA1A1, 16'hA0A0} : 32'hEEEE_EEEE;
            ns_b        = (r == 1) ? lanes4(16'hC000, 16'h0111) : lanes4(16'hEEEE, 16'h0001);
            tick();
            p = r + 1;
            exp64 = {32'd0, (p == 3) ? 16'hA1A1 : 16'h0000, (p == 2) ? 16'hA0A0 : 16'h0000};
            chk("ns_out_a", {32'd0, ns_out_a}, exp64);
            chk("ns_b_lane3", lane(ns_out_b, 3), (p == 5) ? 16'hC333 : 16'd0);
            chk("ns_b_lane1", lane(ns_out_b, 1), (p == 3) ? 16'hC111 : 16'd0);
            chk("ns_done", ns_done, p == 2);
            chk("ns_busy", ns_busy, p < 5);
            chk("ns_in_ready", ns_in_ready, p == 1);
            chk("ns_simd", ns_simd_ctl, 2'b00);
        end
        ns_start    = 1'b0;
        ns_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feed_sequencer.md
# systolic_feed_sequencer

Input-side feed stage for the systolic array wrapper. It accepts one job of `k_len` inner-dimension beats (one A column vector plus one B row vector per beat) over a valid/ready handshake. It applies the diagonal skew the array needs: lane i of A and lane j of B are delayed i and j cycles. Idle slots are zero-filled, and `done_flag` is raised so it can drive the wrapper's `in_done_flag`. It also latches the job's SIMD mode and holds it stable for the array during the job.

## Interface
- `WIDTH`, 16, element width in bits
- `ARR_HEIGHT`, 4, number of A lanes (array rows)
- `ARR_WIDTH`, 4, number of B lanes (array columns)
- `K_BITS`, 8, width of the job-length field
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  job request, sampled only in IDLE
- `k_len`  in  K_BITS  beats in job, sampled with `start`; 0 is illegal
- `simd_mode`  in  2  SIMD mode, sampled with `start`
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `a_vec`  in  ARR_HEIGHT*WIDTH  A column; lane i = bits [i*WIDTH +: WIDTH]
- `b_vec`  in  ARR_WIDTH*WIDTH  B row; lane j = bits [j*WIDTH +: WIDTH]
- `out_a`  out  ARR_HEIGHT*WIDTH  skewed west feed (to `in_a`)
- `out_b`  out  ARR_WIDTH*WIDTH  skewed north feed (to `in_b`)
- `SIMD_control`  out  2  latched mode for the array
- `done_flag`  out  1  one-cycle pulse marking the last beat (to `in_done_flag`)
- `busy`  out  1  high in LOAD and DRAIN

## Operation
- **States:** IDLE, LOAD, DRAIN. Let `D` = max(ARR_HEIGHT, ARR_WIDTH) - 1.
- **IDLE:**
  - `start=1` with `k_len!=0`: latch `k_len` into the remaining counter, latch `simd_mode` into `SIMD_control`, go to LOAD.
  - `start` with `k_len=0` is ignored; state is unchanged.
- **LOAD:**
  - `in_ready=1`. Each accepted beat decrements the counter.
  - The accept that takes the counter to 0 moves the FSM to DRAIN.
  - A cycle with no accept inserts a zero slot on every lane. This is safe because A and B zeros stay slot-aligned, so they contribute 0 to every accumulator.
- **DRAIN:**
  - `in_ready=0`. Zero slots are fed for `D` cycles so the delayed lanes empty.
  - Then the FSM goes to IDLE. If `D=0`, it goes to IDLE on the cycle after the last accept.
- **Skew:**
  - Lane i of A passes through 1+i register stages; lane j of B through 1+j stages.
  - Each stage is a register whose input is the accepted beat's lane value, or 0 in an idle slot.
- **Other outputs:**
  - `busy` = (state != IDLE).
  - `SIMD_control` holds its latched value until the next accepted `start`. It is not cleared in IDLE.
  - `start` while busy is ignored.
- **Reset:**
  - All skew registers, `out_a`, `out_b`, `SIMD_control`, `done_flag`, `busy`, `in_ready` and the counter go to 0; state goes to IDLE.
  - Reset mid-job aborts the job: no `done_flag`, and lanes carry zeros from the next cycle.

## Timing
- Outputs are registered. `in_ready` is a decode of the state register and does not depend on `in_valid`.
- Beat accepted at cycle t:
  - A lane i appears on `out_a` at cycle t+1+i.
  - B lane j appears on `out_b` at cycle t+1+j.
- **`done_flag`:**
  - High for exactly cycle t_last+1, where t_last is the cycle of the final accept. This is the cycle that beat's lane 0 is presented.
  - The downstream wrapper adds its own ARR_WIDTH+ARR_HEIGHT+4 cycle delay.
- **State timing:**
  - First accept is possible at the cycle after `start` is sampled.
  - `busy` rises at that same cycle.
  - `busy` falls at t_last+1+D.
  - A new `start` is accepted in the first IDLE cycle.
- **Minimum job length:** `k_len=1` gives one accept, one `done_flag` and D drain cycles.
- **Counter:** K_BITS wide; `k_len` = 2^K_BITS-1 must complete without wrap.

## Test plan
- **Basic 4x4 job:**
  - Stimulus: `k_len=3`, `in_valid` held high, A beats 0x0011/0x0012/0x0013 per lane, accepts at t=1,2,3.
  - Required: `out_a` lane 2 shows 0x0011,0x0012,0x0013 at t=4,5,6, and 0 otherwise.
  - Required: `done_flag` only at t=4; `busy` falls at t=7.
- **Bubbles:**
  - Stimulus: `k_len=2`, `in_valid` toggled 1,0,1.
  - Required: lane 0 sequence is X,0,Y; lane 3 shows the same sequence shifted 3 cycles.
  - Required: `done_flag` follows the second accept by exactly 1 cycle.
- **Ignored starts:**
  - Stimulus: `start` while busy, and `start` with `k_len=0`.
  - Required: neither changes state, counter or `SIMD_control`.
- **SIMD latch:**
  - Stimulus: `simd_mode=2'b10` sampled at start, then `simd_mode` changed to 2'b01 mid-job.
  - Required: `SIMD_control` stays 2'b10 through the job and after it.
- **Reset mid-LOAD:**
  - Stimulus: assert `reset` after 2 of 5 beats.
  - Required: all outputs 0 the next cycle, no `done_flag` ever, state IDLE.
  - Required: a following `k_len=1` job completes normally.
- **Non-square array:**
  - Setup: ARR_HEIGHT=2, ARR_WIDTH=4, `k_len=1`.
  - Required: B lane 3 appears at t+4.
  - Required: DRAIN lasts 3 cycles, so `busy` falls at t+4.
